// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared constants, port ids and arbiter state type for the Hack data RAM path
package hack_mem_pkg;
    localparam int RAM_WORDS = 2048;
    localparam int HACK_ADDR_W = 16;
    localparam int HACK_DW = 16;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} arb_state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's req/ack transaction bundle
interface ram_arbiter_if #(parameter int DW = hack_mem_pkg::HACK_DW);
    logic req;
    logic we;
    logic [hack_mem_pkg::HACK_ADDR_W-1:0] addr;
    logic [DW-1:0] wdata;
    logic ack;
    logic [DW-1:0] rdata;
    logic err;
    modport master(output req, we, addr, wdata, input ack, rdata, err);
    modport slave(input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick with an exclusion mask
module rr_arb2 import hack_mem_pkg::*; (
    input  logic       req_a,
    input  logic       req_b,
    input  logic [1:0] mask,
    input  logic       rr,
    output logic       grant_valid,
    output logic       grant_port
);
    logic ea, eb;
    // a masked port is invisible; ties go to the rr-preferred port
    always_comb begin
        ea = req_a & ~mask[PORT_A];
        eb = req_b & ~mask[PORT_B];
        grant_valid = ea | eb;
        grant_port = (ea & eb) ? rr : (eb ? PORT_B : PORT_A);
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single Hack data RAM between the CPU (port a) and a loader (port b)
module ram_arbiter import hack_mem_pkg::*; #(
    parameter int DW = hack_mem_pkg::HACK_DW,
    parameter int RAM_WORDS = hack_mem_pkg::RAM_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ram_arbiter_if.slave           a,
    ram_arbiter_if.slave           b,
    output logic [HACK_ADDR_W-1:0] ram_address,
    output logic [DW-1:0]          ram_in,
    output logic                   ram_load,
    input  logic [DW-1:0]          ram_out
);
    localparam logic [HACK_ADDR_W:0] LIMIT = (HACK_ADDR_W+1)'(RAM_WORDS);

    arb_state_t state, next_state;
    logic rr, cur_port, cur_we;
    logic [HACK_ADDR_W-1:0] cur_addr;
    logic [DW-1:0] cur_wdata, a_rdata, b_rdata;
    logic [1:0] mask;
    logic grant_valid, grant_port, in_range, take;

    rr_arb2 u_arb (
        .req_a(a.req),
        .req_b(b.req),
        .mask(mask),
        .rr(rr),
        .grant_valid(grant_valid),
        .grant_port(grant_port)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end

    // next state, RAM pins and per-port responses; the acked port is masked since its req is stale
    always_comb begin
        mask = (state == ACK) ? (cur_port ? 2'b10 : 2'b01) : 2'b00;
        in_range = {1'b0, cur_addr} < LIMIT;
        take = grant_valid && state != ACCESS;
        next_state = (state == ACCESS) ? ACK : (grant_valid ? ACCESS : IDLE);
        ram_load = state == ACCESS && cur_we && in_range && rst_n;
        ram_address = (state == ACCESS) ? cur_addr : '0;
        ram_in = (state == ACCESS) ? cur_wdata : '0;
        a.ack = state == ACK && cur_port == PORT_A;
        b.ack = state == ACK && cur_port == PORT_B;
        a.err = a.ack && !in_range;
        b.err = b.ack && !in_range;
        a.rdata = a_rdata;
        b.rdata = b_rdata;
    end

    // latch the granted request, rotate priority, capture read data at the end of ACCESS
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr <= PORT_A;
            cur_port <= PORT_A;
            cur_we <= 1'b0;
            cur_addr <= '0;
            cur_wdata <= '0;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (take) begin
                cur_port <= grant_port;
                cur_we <= grant_port ? b.we : a.we;
                cur_addr <= grant_port ? b.addr : a.addr;
                cur_wdata <= grant_port ? b.wdata : a.wdata;
                rr <= ~grant_port;
            end
            if (state == ACCESS) begin
                if (cur_port == PORT_A) a_rdata <= in_range ? ram_out : '0;
                else b_rdata <= in_range ? ram_out : '0;
            end
        end
    end
endmodule
